// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - state_t    : FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   - DEF_WIDTH  : default operand/result width
//   - DEF_CNT_W  : default iteration counter width (2**DEF_CNT_W >= DEF_WIDTH)
package seq_restoring_divider_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_restoring_divider_iter_down_counter.sv
// Loadable down-counter that sequences the divider iterations.
// Ports:
//   Clk     : rising-edge clock
//   Reset   : asynchronous active-high reset (Out -> 0)
//   Load    : load LoadVal (priority over En)
//   En      : decrement by one
//   LoadVal : value loaded on Load
//   Out     : current count
//   Zero    : high when Out == 0
module iter_down_counter
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             En,
    input  logic [CNT_W-1:0] LoadVal,
    output logic [CNT_W-1:0] Out,
    output logic             Zero
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out <= '0;
        end else if (Load) begin
            Out <= LoadVal;
        end else if (En) begin
            Out <= Out - CNT_W'(1);
        end
    end

    assign Zero = (Out == '0);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock, Start/Busy/Done
// handshake. Optional signed operation is enabled by defining the macro
// DIVIDER_SIGNED_EN; the default build is unsigned only.
// Ports:
//   Clk       : rising-edge clock
//   Reset     : asynchronous active-high reset
//   Start     : request a division (sampled only in IDLE)
//   Dividend  : numerator, sampled on the accepting edge
//   Divisor   : denominator, sampled on the accepting edge
//   Quotient  : registered result, updated only on completion
//   Remainder : registered result, updated only on completion
//   Busy      : high while iterating (RUN)
//   Done      : one-cycle completion pulse (DONE)
//   DivByZero : Divisor was zero at accept; held until the next accept
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;

    logic             accept;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    logic [CNT_W-1:0] cnt_out;
    logic             cnt_zero;
    logic             cnt_en;

    logic [2*WIDTH-1:0] rq_shift;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   q_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   r_iter;
    logic [WIDTH-1:0]   q_iter;
    logic [WIDTH-1:0]   q_final;
    logic [WIDTH-1:0]   r_final;

    assign accept       = (state == IDLE) && Start;
    assign divisor_zero = (Divisor == '0);

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dividend_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    assign divisor_mag  = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
    // Most-negative magnitude stays 100..0, which is its correct unsigned
    // magnitude, so MIN / -1 wraps back to MIN with no special case.
    assign q_final = neg_q ? -q_iter : q_iter;
    assign r_final = neg_r ? -r_iter : r_iter;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            neg_r <= Dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = Dividend;
    assign divisor_mag  = Divisor;
    assign q_final      = q_iter;
    assign r_final      = r_iter;
`endif

    // One restoring step. R always fits in WIDTH-1 bits before a non-final
    // shift (it is bounded by the dividend prefix), so the shifted-out MSB of
    // R is never significant.
    assign rq_shift = {r_reg, q_reg} << 1;
    assign r_shift  = rq_shift[2*WIDTH-1:WIDTH];
    assign q_shift  = rq_shift[WIDTH-1:0];
    assign trial    = {1'b0, r_shift} - {1'b0, d_reg};
    assign r_iter   = trial[WIDTH] ? r_shift : trial[WIDTH-1:0];
    assign q_iter   = {q_shift[WIDTH-1:1], ~trial[WIDTH]};

    // Counter holds at zero on the final iteration edge instead of wrapping.
    assign cnt_en = (state == RUN) && (cnt_out != '0);

    iter_down_counter #(
        .CNT_W(CNT_W)
    ) u_iter_down_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (accept),
        .En     (cnt_en),
        .LoadVal(CNT_W'(WIDTH - 1)),
        .Out    (cnt_out),
        .Zero   (cnt_zero)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            r_reg     <= '0;
            q_reg     <= dividend_mag;
            d_reg     <= divisor_mag;
            DivByZero <= divisor_zero;
            if (divisor_zero) begin
                Quotient  <= '1;
                Remainder <= Dividend;
            end
        end else if (state == RUN) begin
            r_reg <= r_iter;
            q_reg <= q_iter;
            if (cnt_zero) begin
                Quotient  <= q_final;
                Remainder <= r_final;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed handshake cases
// plus randomized operands against an arithmetic reference model.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 8;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;

    seq_restoring_divider #(
        .WIDTH(WIDTH),
        .CNT_W(3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .DivByZero(DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic from the operand values.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
        int sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = WIDTH'(sa / sb);
            r = WIDTH'(sa % sb);
        end
    endfunction

    // Accept one division, follow it cycle by cycle to Done.
    // hold: keep Start high after accept (returns in the Done cycle).
    // scramble: change the input operands while the division runs.
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit hold, input bit scramble);
        logic [WIDTH-1:0] eq, er;
        int cycles;
        model(a, b, eq, er);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge Clk); #1;
        if (!hold) Start = 1'b0;
        cycles = 1;
        while (!Done && cycles <= int'(WIDTH) + 4) begin
            check_eq("busy_run", Busy, (b != 0));
            check_eq("q_stable", Quotient, prev_q);
            check_eq("r_stable", Remainder, prev_r);
            if (scramble) begin
                Dividend = WIDTH'($urandom);
                Divisor  = WIDTH'($urandom);
            end
            @(posedge Clk); #1;
            cycles++;
        end
        check_eq("done_seen", Done, 1);
        check_eq("latency", cycles, (b == 0) ? 1 : int'(WIDTH) + 1);
        check_eq("quotient", Quotient, eq);
        check_eq("remainder", Remainder, er);
        check_eq("div_by_zero", DivByZero, (b == 0));
        check_eq("busy_done", Busy, 0);
        prev_q = eq;
        prev_r = er;
        if (!hold) begin
            @(posedge Clk); #1;
            check_eq("done_pulse", Done, 0);
            check_eq("busy_idle", Busy, 0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        Reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check_eq("rst_quotient", Quotient, 0);
        check_eq("rst_remainder", Remainder, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Done, 0);
        check_eq("rst_dbz", DivByZero, 0);
        @(posedge Clk); #1;

        // Basic case and divide by zero.
        run_div(8'd200, 8'd7, 1'b0, 1'b1);
        run_div(8'd5, 8'd0, 1'b0, 1'b0);

        // Start held through RUN and into the Done cycle; new operands in the
        // Done cycle are ignored there and accepted one cycle later in IDLE.
        run_div(8'd3, 8'd10, 1'b1, 1'b0);
        Dividend = 8'd255;
        Divisor  = 8'd1;
        @(posedge Clk); #1;
        check_eq("ignore_in_done_busy", Busy, 0);
        check_eq("ignore_in_done_done", Done, 0);
        check_eq("ignore_in_done_q", Quotient, 8'd0);
        run_div(8'd255, 8'd1, 1'b0, 1'b0);

        // Reset mid-run: outputs clear asynchronously, no Done follows.
        Dividend = 8'd100;
        Divisor  = 8'd9;
        Start    = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_eq("abort_quotient", Quotient, 0);
        check_eq("abort_remainder", Remainder, 0);
        check_eq("abort_busy", Busy, 0);
        check_eq("abort_done", Done, 0);
        check_eq("abort_dbz", DivByZero, 0);
        @(posedge Clk); #1;
        Reset  = 1'b0;
        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
            check_eq("no_done_after_abort", Done, 0);
        end
        run_div(8'd100, 8'd9, 1'b0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        run_div(8'hF9, 8'h02, 1'b0, 1'b0);
        run_div(8'h07, 8'hFE, 1'b0, 1'b0);
        run_div(8'h80, 8'hFF, 1'b0, 1'b0);
        run_div(8'h80, 8'h00, 1'b0, 1'b0);
`endif

        // Randomized operands, biased toward edge values.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 8'hFF;
                1:       a = 8'h00;
                2:       a = 8'h80;
                default: a = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1:       b = 8'h01;
                2:       b = 8'hFF;
                default: b = WIDTH'($urandom);
            endcase
            run_div(a, b, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
